// File: rtl/nukv_fifo_writer.sv
// Write-side adapter for nukv_fifogen: ready/valid in, FIFO write port out, with a local
// buffer that absorbs the one-cycle-late almost-full. Stats enabled by NUKV_FIFO_WRITER_STATS_EN.
module nukv_fifo_writer #(
  parameter int ADDR_BITS    = 3,
  parameter int DATA_SIZE    = 16,
  parameter int RESUME_DELAY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [DATA_SIZE-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  input  logic                 m_axis_talmostfull,
  output logic [ADDR_BITS:0]   buf_count,
  output logic [31:0]          stall_count,
  output logic [ADDR_BITS:0]   max_occupancy
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [3:0] RESUME_CNT = 4'(RESUME_DELAY);

  typedef enum logic {FLOW, HOLD} state_t;

  state_t               state_q, state_d;
  logic [3:0]           resume_q, resume_d;
  logic                 af_q;
  logic                 pend_q, pend_d;
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic                 push, pop;

  always_comb begin
    s_axis_tready = (count_q != FULL_CNT);
    // An offered word stays valid until taken, even if HOLD is entered meanwhile.
    m_axis_tvalid = (count_q != '0) && ((state_q == FLOW) || pend_q);
    m_axis_tdata  = mem_q[rd_ptr_q];
    push          = s_axis_tvalid && s_axis_tready;
    pop           = m_axis_tvalid && m_axis_tready;
    pend_d        = m_axis_tvalid && !m_axis_tready;
    wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d       = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    case (state_q)
      FLOW: begin
        resume_d = '0;
        if (af_q) state_d = HOLD;
      end
      HOLD: begin
        if (af_q) resume_d = '0;
        else if (resume_q == RESUME_CNT) begin
          state_d  = FLOW;
          resume_d = '0;
        end else resume_d = resume_q + 1'b1;
      end
      default: state_d = FLOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FLOW;
      resume_q <= '0;
      af_q     <= 1'b0;
      pend_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      af_q     <= m_axis_talmostfull;
      pend_q   <= pend_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= s_axis_tdata;
  end

  assign buf_count = count_q;

`ifdef NUKV_FIFO_WRITER_STATS_EN
  logic [31:0]        stall_q, stall_d;
  logic [ADDR_BITS:0] max_q, max_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == HOLD) && (count_q != '0) && (stall_q != '1)) stall_d = stall_q + 1'b1;
    max_d = (count_q > max_q) ? count_q : max_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      max_q   <= '0;
    end else begin
      stall_q <= stall_d;
      max_q   <= max_d;
    end
  end

  assign stall_count   = stall_q;
  assign max_occupancy = max_q;
`else
  assign stall_count   = '0;
  assign max_occupancy = '0;
`endif
endmodule
